// File: rtl/vec_reg_file_p.sv
// ============================================================================
// Module      : vec_reg_file_p
// Description : Vector/scalar register file with self-clearing INIT sequence,
//               same-cycle write forwarding and optional write counters
//               (enabled by defining VRF_PERF_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vec_reg_file_p #(
    parameter int LANES = 16,
    parameter int WIDTH = 32,
    parameter int NREGS = 16,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        we,
    input  logic                        wsel_v,
    input  logic [AW-1:0]               waddr,
    input  logic [LANES-1:0][WIDTH-1:0] wdata,
    input  logic [LANES-1:0]            wmask,
    input  logic [AW-1:0]               ra1,
    input  logic [AW-1:0]               ra2,
    input  logic                        rsel_v,
    input  logic [WIDTH-1:0]            pc_in,
    output logic [LANES-1:0][WIDTH-1:0] rd1,
    output logic [LANES-1:0][WIDTH-1:0] rd2,
    output logic                        ready,
    output logic [31:0]                 perf_wr_vec,
    output logic [31:0]                 perf_wr_scl
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    typedef enum logic [0:0] {
        S_INIT  = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t                        state_q;
    logic [AW-1:0]                 idx_q;
    logic                          ready_q;

    logic [LANES-1:0][WIDTH-1:0]   vreg_q [NREGS];
    logic [WIDTH-1:0]              sreg_q [NREGS-1];

    logic                          wr_vec;
    logic                          wr_scl;

    assign wr_vec = ready_q & we & wsel_v;
    assign wr_scl = ready_q & we & ~wsel_v;
    assign ready  = ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
            idx_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                S_INIT: begin
                    if (idx_q == LAST_IDX) begin
                        state_q <= S_READY;
                        ready_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_READY;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Storage is cleared one index per cycle by INIT rather than by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == S_INIT) begin
                vreg_q[idx_q] <= '0;
                if (idx_q != LAST_IDX)
                    sreg_q[idx_q] <= '0;
            end else if (wr_vec) begin
                for (int i = 0; i < LANES; i++) begin
                    if (wmask[i])
                        vreg_q[waddr][i] <= wdata[i];
                end
            end else if (wr_scl && (waddr != LAST_IDX)) begin
                sreg_q[waddr] <= wdata[LANES-1];
            end
        end
    end

    function automatic logic [LANES-1:0][WIDTH-1:0] read_port(input logic [AW-1:0] ra);
        logic [LANES-1:0][WIDTH-1:0] r;
        r = '0;
        if (ready_q) begin
            r = vreg_q[ra];
            for (int i = 0; i < LANES; i++) begin
                if (wr_vec && (waddr == ra) && wmask[i])
                    r[i] = wdata[i];
            end
            if (!rsel_v && (ra != LAST_IDX)) begin
                r[LANES-1] = sreg_q[ra];
                if (wr_scl && (waddr == ra))
                    r[LANES-1] = wdata[LANES-1];
            end
        end
        // The PC slot is live even while INIT is clearing storage.
        if (!rsel_v && (ra == LAST_IDX))
            r[LANES-1] = pc_in;
        return r;
    endfunction

    always_comb begin
        rd1 = read_port(ra1);
        rd2 = read_port(ra2);
    end

`ifdef VRF_PERF_EN
    logic [31:0] perf_vec_q, perf_vec_d;
    logic [31:0] perf_scl_q, perf_scl_d;

    always_comb begin
        perf_vec_d = perf_vec_q;
        perf_scl_d = perf_scl_q;
        if (wr_vec && (perf_vec_q != 32'hFFFF_FFFF))
            perf_vec_d = perf_vec_q + 32'd1;
        if (wr_scl && (perf_scl_q != 32'hFFFF_FFFF))
            perf_scl_d = perf_scl_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_vec_q <= '0;
            perf_scl_q <= '0;
        end else begin
            perf_vec_q <= perf_vec_d;
            perf_scl_q <= perf_scl_d;
        end
    end

    assign perf_wr_vec = perf_vec_q;
    assign perf_wr_scl = perf_scl_q;
`else
    assign perf_wr_vec = '0;
    assign perf_wr_scl = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vec_reg_file_p.sv
// ============================================================================
// Module      : tb_vec_reg_file_p
// Description : Scoreboard-driven bench for vec_reg_file_p (default params).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vec_reg_file_p;

    localparam int L  = 16;
    localparam int W  = 32;
    localparam int N  = 16;
    localparam int AW = 4;

    logic                clk;
    logic                rst;
    logic                we;
    logic                wsel_v;
    logic [AW-1:0]       waddr;
    logic [L-1:0][W-1:0] wdata;
    logic [L-1:0]        wmask;
    logic [AW-1:0]       ra1;
    logic [AW-1:0]       ra2;
    logic                rsel_v;
    logic [W-1:0]        pc_in;
    logic [L-1:0][W-1:0] rd1;
    logic [L-1:0][W-1:0] rd2;
    logic                ready;
    logic [31:0]         perf_wr_vec;
    logic [31:0]         perf_wr_scl;

    vec_reg_file_p #(.LANES(L), .WIDTH(W), .NREGS(N)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .we          (we),
        .wsel_v      (wsel_v),
        .waddr       (waddr),
        .wdata       (wdata),
        .wmask       (wmask),
        .ra1         (ra1),
        .ra2         (ra2),
        .rsel_v      (rsel_v),
        .pc_in       (pc_in),
        .rd1         (rd1),
        .rd2         (rd2),
        .ready       (ready),
        .perf_wr_vec (perf_wr_vec),
        .perf_wr_scl (perf_wr_scl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests;
    int n_fail;
    logic [L*W-1:0] exp_q [$];
    logic [L-1:0][W-1:0] e;

    task automatic check_val(input string tag, input logic [L*W-1:0] obs, input logic [L*W-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input logic [L*W-1:0] v);
        exp_q.push_back(v);
    endtask

    task automatic sb_check(input string tag, input logic [L*W-1:0] obs);
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, got %h", tag, obs);
        end else begin
            check_val(tag, obs, exp_q.pop_front());
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we = 1'b0; wsel_v = 1'b0; waddr = '0; wmask = '0; wdata = '0;
    endtask

    task automatic check_init_run(input string tag);
        for (int c = 0; c < N; c++) begin
            #1;
            sb_push('0);
            sb_check(tag, {{(L*W-1){1'b0}}, ready});
            tick();
        end
        sb_push(1);
        sb_check({tag, "_high"}, {{(L*W-1){1'b0}}, ready});
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        idle_inputs();
        ra1 = '0; ra2 = '0; rsel_v = 1'b1;
        pc_in = 32'h100;
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // INIT: ready low for 16 cycles, reads zero, write at cycle 5 dropped
        for (int c = 0; c < N; c++) begin
            idle_inputs();
            rsel_v = 1'b1; ra1 = 4'd5; ra2 = 4'd3;
            if (c == 2) begin rsel_v = 1'b0; ra1 = 4'd15; end
            if (c == 5) begin
                we = 1'b1; wsel_v = 1'b1; waddr = 4'd5; wmask = '1;
                for (int i = 0; i < L; i++) wdata[i] = 32'hA500 + i;
            end
            #1;
            sb_push('0);
            sb_check("init_ready", {{(L*W-1){1'b0}}, ready});
            e = '0;
            if (c == 2) e[L-1] = 32'h100;
            sb_push(e);
            sb_check("init_rd1", rd1);
            if (c == 0 || c == 5) begin
                sb_push('0);
                sb_check("init_rd2", rd2);
            end
            tick();
        end
        idle_inputs();
        sb_push(1);
        sb_check("ready_high", {{(L*W-1){1'b0}}, ready});

        // Every vector register reads zero after INIT (reg 5 write was dropped)
        rsel_v = 1'b1;
        for (int r = 0; r < N; r++) begin
            ra1 = AW'(r); ra2 = AW'(r);
            #1;
            sb_push('0); sb_check("post_init_rd1", rd1);
            sb_push('0); sb_check("post_init_rd2", rd2);
        end
        rsel_v = 1'b0; ra1 = 4'd15; ra2 = 4'd2;
        #1;
        e = '0; e[L-1] = 32'h100;
        sb_push(e); sb_check("pc_slot", rd1);
        sb_push('0); sb_check("scalar_zero", rd2);
        sb_push('0);
        sb_check("perf_init", {{(L*W-64){1'b0}}, perf_wr_vec, perf_wr_scl});

        // Masked vector write to reg 3 with forwarding in the write cycle
        we = 1'b1; wsel_v = 1'b1; waddr = 4'd3; wmask = 16'h00FF;
        for (int i = 0; i < L; i++) wdata[i] = W'(i + 1);
        rsel_v = 1'b1; ra1 = 4'd3; ra2 = 4'd4;
        e = '0;
        for (int i = 0; i < 8; i++) e[i] = W'(i + 1);
        #1;
        sb_push(e); sb_check("vwr_fwd", rd1);
        sb_push('0); sb_check("vwr_other", rd2);
        tick();
        idle_inputs();
        #1;
        sb_push(e); sb_check("vwr_persist", rd1);

        // Scalar write to reg 4, forwarded then stored; vector lanes untouched
        we = 1'b1; wsel_v = 1'b0; waddr = 4'd4; wmask = '1;
        for (int i = 0; i < L-1; i++) wdata[i] = 32'hBAD0 + i;
        wdata[L-1] = 32'hDEAD;
        rsel_v = 1'b0; ra2 = 4'd4; ra1 = 4'd3;
        e = '0; e[L-1] = 32'hDEAD;
        #1;
        sb_push(e); sb_check("swr_fwd", rd2);
        tick();
        idle_inputs();
        #1;
        sb_push(e); sb_check("swr_persist", rd2);
        e = '0;
        for (int i = 0; i < 8; i++) e[i] = W'(i + 1);
        sb_push(e); sb_check("scalar_view_r3", rd1);
        rsel_v = 1'b1;
        #1;
        sb_push('0); sb_check("vec_view_r4", rd2);

        // Scalar write to index 15: accepted but pc slot unaffected
        we = 1'b1; wsel_v = 1'b0; waddr = 4'd15; wdata[L-1] = 32'h1234;
        rsel_v = 1'b0; ra1 = 4'd15;
        #1;
        e = '0; e[L-1] = 32'h100;
        sb_push(e); sb_check("pc_no_fwd", rd1);
        tick();
        idle_inputs();
        #1;
        sb_push(e); sb_check("pc_after_wr", rd1);

        // Vector write with empty mask (accepted, no change), then full write to reg 7
        we = 1'b1; wsel_v = 1'b1; waddr = 4'd6; wmask = '0; wdata = '1;
        tick();
        waddr = 4'd7; wmask = '1;
        for (int i = 0; i < L; i++) wdata[i] = 32'h7000 + i;
        tick();
        idle_inputs();
        rsel_v = 1'b1; ra1 = 4'd6; ra2 = 4'd7;
        #1;
        sb_push('0); sb_check("mask0_r6", rd1);
        for (int i = 0; i < L; i++) e[i] = 32'h7000 + i;
        sb_push(e); sb_check("vec_r7", rd2);
        rsel_v = 1'b0;
        #1;
        e[L-1] = '0;
        sb_push(e); sb_check("scalar_view_r7", rd2);

`ifdef VRF_PERF_EN
        sb_push({{(L*W-64){1'b0}}, 32'd3, 32'd2});
`else
        sb_push('0);
`endif
        sb_check("perf_counts", {{(L*W-64){1'b0}}, perf_wr_vec, perf_wr_scl});

        // Reset mid-INIT at cycle 8 restarts the full sequence
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 8; c++) tick();
        sb_push('0);
        sb_check("mid_init_ready", {{(L*W-1){1'b0}}, ready});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_init_run("restart_ready");
        sb_push('0);
        sb_check("perf_after_rst", {{(L*W-64){1'b0}}, perf_wr_vec, perf_wr_scl});
        rsel_v = 1'b1; ra1 = 4'd3; ra2 = 4'd7;
        #1;
        sb_push('0); sb_check("r3_cleared", rd1);
        sb_push('0); sb_check("r7_cleared", rd2);
        rsel_v = 1'b0; ra2 = 4'd4;
        #1;
        sb_push('0); sb_check("s4_cleared", rd2);

        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
